// File: rtl/otter_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_hazard_pkg
//  Description : Shared types and constants for the pipeline hazard controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package otter_hazard_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [4:0] REG_X0 = 5'd0;

  // Wide enough for the largest legal MEM_TIMEOUT (255).
  localparam int WAIT_W = 8;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_select
//  Description : ALU operand forward select; MEM result wins over WB result.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_select
  import otter_hazard_pkg::*;
(
  input  logic [4:0] ex_rs_i,
  input  logic [4:0] mem_rd_i,
  input  logic       mem_regwrite_i,
  input  logic [4:0] wb_rd_i,
  input  logic       wb_regwrite_i,
  output logic [1:0] fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (mem_regwrite_i && (mem_rd_i != REG_X0) && (mem_rd_i == ex_rs_i)) begin
      fwd_o = FWD_MEM;
    end else if (wb_regwrite_i && (wb_rd_i != REG_X0) && (wb_rd_i == ex_rs_i)) begin
      fwd_o = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : 5-stage pipeline hazard unit: forwarding, load-use stall,
//                branch flush, data-memory wait/timeout and stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
  import otter_hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rs1_i,
  input  logic [4:0]       ex_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_regwrite_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_regwrite_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             wb_regwrite_i,
  input  logic             br_taken_i,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  input  logic             cnt_clr_i,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic             stall_if_o,
  output logic             bubble_ex_o,
  output logic             flush_ifid_o,
  output logic             freeze_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [WAIT_W-1:0] TIMEOUT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  hz_state_e          state_q, state_d;
  logic               br_pend_q, br_pend_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic [1:0]         fwd_a_raw, fwd_b_raw;
  logic               load_use;
  logic               mem_req_stall;
  logic               timeout;
  logic               unused_ex_regwrite;

  // The load flag alone identifies a load; the write-enable is redundant here.
  assign unused_ex_regwrite = ex_regwrite_i;

  fwd_select u_fwd_a (
    .ex_rs_i        (ex_rs1_i),
    .mem_rd_i       (mem_rd_i),
    .mem_regwrite_i (mem_regwrite_i),
    .wb_rd_i        (wb_rd_i),
    .wb_regwrite_i  (wb_regwrite_i),
    .fwd_o          (fwd_a_raw)
  );

  fwd_select u_fwd_b (
    .ex_rs_i        (ex_rs2_i),
    .mem_rd_i       (mem_rd_i),
    .mem_regwrite_i (mem_regwrite_i),
    .wb_rd_i        (wb_rd_i),
    .wb_regwrite_i  (wb_regwrite_i),
    .fwd_o          (fwd_b_raw)
  );

  assign fwd_a_o = rst_ni ? fwd_a_raw : FWD_RF;
  assign fwd_b_o = rst_ni ? fwd_b_raw : FWD_RF;

  assign load_use = ex_memread_i && (ex_rd_i != REG_X0) &&
                    ((id_use_rs1_i && (id_rs1_i == ex_rd_i)) ||
                     (id_use_rs2_i && (id_rs2_i == ex_rd_i)));

  assign mem_req_stall = dmem_req_i && !dmem_ack_i;

  // Fires on the MEM_TIMEOUT-th wait cycle; an ack in the same cycle wins.
  assign timeout = (state_q == ST_MEM_WAIT) && !dmem_ack_i && (wait_q == TIMEOUT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      br_pend_q   <= 1'b0;
      wait_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      br_pend_q   <= br_pend_d;
      wait_q      <= wait_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    br_pend_d = br_pend_q;
    wait_d    = wait_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req_stall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
          if (br_taken_i) begin
            br_pend_d = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ack_i || timeout) begin
          state_d = br_pend_q ? ST_FLUSH : ST_RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_FLUSH: begin
        state_d   = ST_RUN;
        br_pend_d = 1'b0;
      end
      default: begin
        state_d   = ST_RUN;
        br_pend_d = 1'b0;
        wait_d    = '0;
      end
    endcase
  end

  always_comb begin
    stall_if_o   = 1'b0;
    bubble_ex_o  = 1'b0;
    flush_ifid_o = 1'b0;
    freeze_o     = 1'b0;
    mem_err_o    = 1'b0;
    if (rst_ni) begin
      case (state_q)
        ST_RUN: begin
          if (mem_req_stall) begin
            freeze_o = 1'b1;
          end else if (br_taken_i) begin
            flush_ifid_o = 1'b1;
            bubble_ex_o  = 1'b1;
          end else if (load_use) begin
            stall_if_o  = 1'b1;
            bubble_ex_o = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          if (timeout) begin
            mem_err_o = 1'b1;
          end else if (!dmem_ack_i) begin
            freeze_o = 1'b1;
          end
        end
        ST_FLUSH: begin
          flush_ifid_o = 1'b1;
          bubble_ex_o  = 1'b1;
        end
        default: begin
          freeze_o = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
    end else if ((stall_if_o || freeze_o) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Self-checking bench for hazard_ctrl with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int TO   = 15;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic br_taken, dmem_req, dmem_ack, cnt_clr;
  logic [1:0] fwd_a, fwd_b;
  logic stall_if, bubble_ex, flush_ifid, freeze, mem_err;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  // Behavioural model state: wait-phase flag, wait cycles spent, branch owed, flush owed, stall count.
  int m_wait, m_wcnt, m_pend, m_flush, m_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1), .id_use_rs2_i(id_use_rs2),
    .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2), .ex_rd_i(ex_rd),
    .ex_regwrite_i(ex_regwrite), .ex_memread_i(ex_memread),
    .mem_rd_i(mem_rd), .mem_regwrite_i(mem_regwrite), .wb_rd_i(wb_rd), .wb_regwrite_i(wb_regwrite),
    .br_taken_i(br_taken), .dmem_req_i(dmem_req), .dmem_ack_i(dmem_ack), .cnt_clr_i(cnt_clr),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_if_o(stall_if), .bubble_ex_o(bubble_ex),
    .flush_ifid_o(flush_ifid), .freeze_o(freeze), .mem_err_o(mem_err), .stall_cnt_o(stall_cnt)
  );

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    br_taken = 0; dmem_req = 0; dmem_ack = 0; cnt_clr = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_count();
    idle();
    cnt_clr = 1;
    next_cycle();
    cnt_clr = 0;
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (mem_regwrite && mem_rd != 5'd0 && mem_rd == rs) return 2'b01;
    if (wb_regwrite && wb_rd != 5'd0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_reset();
    idle();
    rst_n = 0;
    ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1; dmem_req = 1; br_taken = 1;
    ex_rs1 = 4; ex_rs2 = 4; mem_rd = 4; mem_regwrite = 1; wb_rd = 4; wb_regwrite = 1;
    @(negedge clk);
    checks++;
    if ({stall_if, bubble_ex, flush_ifid, freeze, mem_err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000", {stall_if, bubble_ex, flush_ifid, freeze, mem_err});
    end
    checks++;
    if ({fwd_a, fwd_b} !== 4'b0) begin
      failures++;
      $display("FAIL reset_fwd: got %b expected 0000", {fwd_a, fwd_b});
    end
    checks++;
    if (stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
    end
    next_cycle();
    idle();
    #2 rst_n = 1;
    @(negedge clk);
    checks++;
    if ({stall_if, bubble_ex, flush_ifid, freeze, mem_err, stall_cnt} !== 9'b0) begin
      failures++;
      $display("FAIL reset_idle: got %b expected all zero", {stall_if, bubble_ex, flush_ifid, freeze, mem_err, stall_cnt});
    end
    next_cycle();
  endtask

  task automatic test_forward();
    logic [4:0] t_rs [7] = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd0, 5'd5};
    logic [4:0] t_mrd[7] = '{5'd5, 5'd5, 5'd0, 5'd6, 5'd6, 5'd0, 5'd5};
    logic       t_mw [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [4:0] t_wrd[7] = '{5'd5, 5'd5, 5'd0, 5'd5, 5'd7, 5'd0, 5'd6};
    logic       t_ww [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [1:0] t_exp[7] = '{2'b01, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    idle();
    for (int side = 0; side < 2; side++) begin
      for (int i = 0; i < 7; i++) begin
        mem_rd = t_mrd[i]; mem_regwrite = t_mw[i]; wb_rd = t_wrd[i]; wb_regwrite = t_ww[i];
        if (side == 0) begin ex_rs1 = t_rs[i]; ex_rs2 = 5'd31; end
        else           begin ex_rs2 = t_rs[i]; ex_rs1 = 5'd30; end
        #1;
        checks++;
        if (side == 0 && (fwd_a !== t_exp[i] || fwd_b !== 2'b00)) begin
          failures++;
          $display("FAIL fwd_a[%0d]: got a=%b b=%b expected a=%b b=00", i, fwd_a, fwd_b, t_exp[i]);
        end
        if (side == 1 && (fwd_b !== t_exp[i] || fwd_a !== 2'b00)) begin
          failures++;
          $display("FAIL fwd_b[%0d]: got a=%b b=%b expected a=00 b=%b", i, fwd_a, fwd_b, t_exp[i]);
        end
      end
    end
    idle();
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [4:0] t_rd  [5] = '{5'd7, 5'd7, 5'd7, 5'd0, 5'd3};
    logic       t_mr  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0] t_rs2 [5] = '{5'd7, 5'd7, 5'd7, 5'd0, 5'd9};
    logic       t_u2  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       t_stl [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    clear_count();
    for (int i = 0; i < 5; i++) begin
      ex_rd = t_rd[i]; ex_memread = t_mr[i]; ex_regwrite = t_mr[i];
      id_rs2 = t_rs2[i]; id_use_rs2 = t_u2[i]; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
      @(negedge clk);
      checks++;
      if (stall_if !== t_stl[i] || bubble_ex !== t_stl[i] || flush_ifid !== 1'b0 || freeze !== 1'b0) begin
        failures++;
        $display("FAIL load_use[%0d]: got stall=%b bubble=%b flush=%b freeze=%b expected stall=bubble=%b", i, stall_if, bubble_ex, flush_ifid, freeze, t_stl[i]);
      end
      if (i == 1) begin
        checks++;
        if (stall_cnt !== 4'd1) begin
          failures++;
          $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt);
        end
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd2) begin
      failures++;
      $display("FAIL load_use_cnt2: got %0d expected 2", stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_mem_wait();
    clear_count();
    for (int i = 0; i < 5; i++) begin
      dmem_req = 1; dmem_ack = (i == 4); br_taken = (i == 2);
      @(negedge clk);
      checks++;
      if (freeze !== (i < 4) || flush_ifid !== 1'b0 || bubble_ex !== 1'b0 || mem_err !== 1'b0) begin
        failures++;
        $display("FAIL mem_wait[%0d]: got freeze=%b flush=%b bubble=%b err=%b expected freeze=%b", i, freeze, flush_ifid, bubble_ex, mem_err, (i < 4));
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (freeze !== 1'b0 || flush_ifid !== 1'b0 || stall_cnt !== 4'd4) begin
      failures++;
      $display("FAIL mem_wait_exit: got freeze=%b flush=%b cnt=%0d expected 0 0 4", freeze, flush_ifid, stall_cnt);
    end
    next_cycle();
  endtask

  task automatic test_branch_wait();
    logic [5:0] e_fz = 6'b000111;
    logic [5:0] e_fl = 6'b010000;
    // Plain branch in RUN outranks a concurrent load-use.
    idle();
    br_taken = 1; ex_memread = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
    @(negedge clk);
    checks++;
    if (flush_ifid !== 1'b1 || bubble_ex !== 1'b1 || stall_if !== 1'b0 || freeze !== 1'b0) begin
      failures++;
      $display("FAIL branch_run: got flush=%b bubble=%b stall=%b freeze=%b expected 1 1 0 0", flush_ifid, bubble_ex, stall_if, freeze);
    end
    next_cycle();
    for (int i = 0; i < 6; i++) begin
      idle();
      dmem_req = (i < 4); dmem_ack = (i == 3); br_taken = (i == 0);
      if (i == 4) begin
        dmem_req = 1; ex_memread = 1; ex_rd = 4; id_rs1 = 4; id_use_rs1 = 1;
      end
      @(negedge clk);
      checks++;
      if (freeze !== e_fz[i] || flush_ifid !== e_fl[i] || bubble_ex !== e_fl[i] || stall_if !== 1'b0) begin
        failures++;
        $display("FAIL branch_wait[%0d]: got freeze=%b flush=%b bubble=%b stall=%b expected freeze=%b flush=bubble=%b", i, freeze, flush_ifid, bubble_ex, stall_if, e_fz[i], e_fl[i]);
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_timeout();
    idle();
    dmem_req = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (freeze !== (i < 15) || mem_err !== (i == 15)) begin
        failures++;
        $display("FAIL timeout[%0d]: got freeze=%b err=%b expected freeze=%b err=%b", i, freeze, mem_err, (i < 15), (i == 15));
      end
      next_cycle();
    end
    dmem_req = 0; ex_memread = 1; ex_rd = 6; id_rs2 = 6; id_use_rs2 = 1;
    @(negedge clk);
    checks++;
    if (stall_if !== 1'b1 || freeze !== 1'b0 || mem_err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_run: got stall=%b freeze=%b err=%b expected 1 0 0", stall_if, freeze, mem_err);
    end
    next_cycle();
    idle();
    dmem_req = 1;
    for (int i = 0; i < 6; i++) next_cycle();
    #2 rst_n = 0;
    #1;
    checks++;
    if ({stall_if, bubble_ex, flush_ifid, freeze, mem_err} !== 5'b0 || stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_wait: got ctrl=%b cnt=%0d expected 00000 0", {stall_if, bubble_ex, flush_ifid, freeze, mem_err}, stall_cnt);
    end
    next_cycle();
    dmem_req = 0;
    #2 rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (mem_err !== 1'b0 || freeze !== 1'b0) begin
        failures++;
        $display("FAIL post_reset[%0d]: got err=%b freeze=%b expected 0 0", i, mem_err, freeze);
      end
      next_cycle();
    end
  endtask

  task automatic test_saturate();
    clear_count();
    ex_memread = 1; ex_rd = 2; id_rs1 = 2; id_use_rs1 = 1;
    for (int i = 0; i < 18; i++) next_cycle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd15) begin
      failures++;
      $display("FAIL saturate: got %0d expected 15", stall_cnt);
    end
    cnt_clr = 1;
    next_cycle();
    cnt_clr = 0;
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL clr_priority: got %0d expected 0", stall_cnt);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL count_after_clr: got %0d expected 1", stall_cnt);
    end
    idle();
    next_cycle();
  endtask

  task automatic test_random();
    logic e_st, e_bub, e_fl, e_fz, e_err, lu;
    idle();
    rst_n = 0;
    next_cycle();
    rst_n = 1;
    m_wait = 0; m_wcnt = 0; m_pend = 0; m_flush = 0; m_cnt = 0;
    for (int n = 0; n < 600; n++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom_range(0, 1)); id_use_rs2 = 1'($urandom_range(0, 1));
      ex_regwrite = 1'($urandom_range(0, 1)); ex_memread = 1'($urandom_range(0, 1));
      mem_regwrite = 1'($urandom_range(0, 1)); wb_regwrite = 1'($urandom_range(0, 1));
      br_taken = ($urandom_range(0, 3) == 0);
      dmem_req = ($urandom_range(0, 3) == 0);
      dmem_ack = (m_wait != 0) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 3) == 0);
      cnt_clr  = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      e_st = 0; e_bub = 0; e_fl = 0; e_fz = 0; e_err = 0;
      lu = ex_memread && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      if (m_flush != 0) begin
        e_fl = 1; e_bub = 1;
      end else if (m_wait != 0) begin
        if (!dmem_ack && m_wcnt + 1 == TO) e_err = 1;
        else if (!dmem_ack) e_fz = 1;
      end else if (dmem_req && !dmem_ack) begin
        e_fz = 1;
      end else if (br_taken) begin
        e_fl = 1; e_bub = 1;
      end else if (lu) begin
        e_st = 1; e_bub = 1;
      end
      checks++;
      if ({stall_if, bubble_ex, flush_ifid, freeze, mem_err} !== {e_st, e_bub, e_fl, e_fz, e_err}) begin
        failures++;
        $display("FAIL rand_ctrl[%0d]: got %b expected %b (stall,bubble,flush,freeze,err)", n, {stall_if, bubble_ex, flush_ifid, freeze, mem_err}, {e_st, e_bub, e_fl, e_fz, e_err});
      end
      checks++;
      if (fwd_a !== fwd_ref(ex_rs1) || fwd_b !== fwd_ref(ex_rs2)) begin
        failures++;
        $display("FAIL rand_fwd[%0d]: got a=%b b=%b expected a=%b b=%b", n, fwd_a, fwd_b, fwd_ref(ex_rs1), fwd_ref(ex_rs2));
      end
      checks++;
      if (int'(stall_cnt) != m_cnt) begin
        failures++;
        $display("FAIL rand_cnt[%0d]: got %0d expected %0d", n, stall_cnt, m_cnt);
      end
      if (m_flush != 0) begin
        m_flush = 0; m_pend = 0;
      end else if (m_wait != 0) begin
        if (dmem_ack || m_wcnt + 1 == TO) begin
          m_wait = 0; m_wcnt = 0; m_flush = m_pend;
        end else begin
          m_wcnt++;
        end
      end else if (dmem_req && !dmem_ack) begin
        m_wait = 1; m_wcnt = 0;
        if (br_taken) m_pend = 1;
      end
      if (cnt_clr) m_cnt = 0;
      else if ((e_st || e_fz) && m_cnt < CMAX) m_cnt++;
      next_cycle();
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_mem_wait();
    test_branch_wait();
    test_timeout();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, SHALL set the maximum MEM_WAIT cycles before abort (legal 1..255).
REQ-002 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST_N  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 id_rs1, id_rs2  in  5 each, with id_use_rs1, id_use_rs2  in  1 each  SHALL give the decode-stage sources and their valid bits.
REQ-006 ex_rs1, ex_rs2  in  5 each  SHALL give the execute-stage sources.
REQ-007 ex_rd  in  5, with ex_regwrite and ex_memread  in  1 each  SHALL describe the execute-stage destination and load flag.
REQ-008 mem_rd  in  5 with mem_regwrite  in  1, and wb_rd  in  5 with wb_regwrite  in  1  SHALL describe the MEM and WB destinations.
REQ-009 br_taken  in  1  SHALL be the taken branch/jump resolved in EX.
REQ-010 dmem_req, dmem_ack  in  1 each  SHALL be the MEM-stage data-memory request and completion.
REQ-011 cnt_clr  in  1  SHALL be the synchronous stall-counter clear.
REQ-012 fwd_a, fwd_b  out  2 each  SHALL be the ALU srcA/srcB forward selects: 00 regfile, 01 MEM, 10 WB.
REQ-013 stall_if  out  1  SHALL hold the PC and IF/ID; bubble_ex out 1 SHALL load a NOP into ID/EX; flush_ifid out 1 SHALL clear IF/ID; freeze out 1 SHALL hold every pipeline register.
REQ-014 mem_err  out  1  SHALL be a one-cycle memory-timeout pulse; stall_cnt  out  CNT_W  SHALL be the stall-cycle count.

Function
REQ-015 fwd_a SHALL be combinational: 01 if mem_regwrite, mem_rd!=0 and mem_rd==ex_rs1; else 10 if wb_regwrite, wb_rd!=0 and wb_rd==ex_rs1; else 00. fwd_b SHALL follow the same rule using ex_rs2.
REQ-016 The forward selects SHALL be independent of FSM state, so MEM takes priority over WB when both match.
REQ-017 The FSM SHALL have states RUN, MEM_WAIT and FLUSH.
REQ-018 Control outputs SHALL be Mealy on state plus inputs.
REQ-019 In RUN with dmem_req=1 and dmem_ack=0: freeze=1 and next state MEM_WAIT; if br_taken=1 in that cycle, br_pend SHALL be set to 1.
REQ-020 In RUN with no freeze and br_taken=1: flush_ifid=1 and bubble_ex=1 in that same cycle; next state RUN.
REQ-021 In RUN with no freeze and no branch: load-use (ex_memread=1, ex_rd!=0, and ex_rd matches id_rs1 with id_use_rs1 or id_rs2 with id_use_rs2) SHALL give stall_if=1 and bubble_ex=1 for exactly one cycle.
REQ-022 RUN priority SHALL be freeze, then branch flush, then load-use.
REQ-023 In MEM_WAIT: freeze=1 and all other control outputs 0; the wait counter SHALL increment each cycle; br_taken SHALL be ignored (EX is frozen).
REQ-024 MEM_WAIT with dmem_ack=1 SHALL deassert freeze in that cycle; next state FLUSH if br_pend=1, else RUN.
REQ-025 If the wait counter reaches MEM_TIMEOUT without ack: mem_err=1 for one cycle, freeze=0, and exit as in REQ-024.
REQ-026 FLUSH SHALL last one cycle with flush_ifid=1 and bubble_ex=1, clear br_pend, and return to RUN; a load-use is not evaluated in FLUSH.
REQ-027 stall_cnt SHALL increment in every cycle where stall_if or freeze is 1, and saturate at all-ones.
REQ-028 cnt_clr SHALL zero stall_cnt on the next edge and take precedence over increment.

Reset
REQ-029 RST_N=0 SHALL immediately set state RUN, br_pend 0, wait counter 0, stall_cnt 0 and mem_err 0.
REQ-030 While RST_N=0, stall_if, bubble_ex, flush_ifid and freeze SHALL be forced to 0 and fwd_a/fwd_b to 00.
REQ-031 Reset asserted mid-MEM_WAIT SHALL abandon the wait with no mem_err pulse.

Structure
REQ-032 Package otter_hazard_pkg SHALL hold the state enum and constants FWD_RF=00, FWD_MEM=01, FWD_WB=10 and REG_X0=0.
REQ-033 One sub-module, fwd_select, SHALL implement REQ-015 and be instantiated once per ALU operand.

Verification
REQ-034 ex_rs1=5, mem_rd=5/mem_regwrite=1, wb_rd=5/wb_regwrite=1 -> fwd_a=01; with mem_regwrite=0 -> fwd_a=10; with mem_rd=0 and wb_rd=0 -> fwd_a=00.
REQ-035 ex_memread=1, ex_rd=7, id_rs2=7, id_use_rs2=1 -> stall_if=1 and bubble_ex=1 for exactly one cycle; stall_cnt +1.
REQ-036 dmem_req=1 with ack after 4 cycles -> freeze=1 for 4 cycles then 0 in the ack cycle; stall_cnt +4.
REQ-037 br_taken=1 coinciding with the dmem_req stall start, ack 3 cycles later -> freeze cycles, then one FLUSH cycle (flush_ifid=bubble_ex=1), then RUN.
REQ-038 dmem_req=1 with no ack, MEM_TIMEOUT=15 -> mem_err=1 on the 15th wait cycle, then RUN; RST_N pulse during a second wait -> RUN, no mem_err.
